// File: rtl/compare_sort_ctrl_pkg.sv
// Shared constants for the compare/sort controller: state encodings,
// comparator and swap-counter widths, and the saturating counter helper.
package compare_sort_ctrl_pkg;

   localparam int CMP_W  = 4;
   localparam int SWAP_W = 6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SORT = 2'd2;
   localparam logic [1:0] ST_OUT  = 2'd3;

   typedef logic [SWAP_W-1:0] swap_cnt_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic swap_cnt_t sat_inc(input swap_cnt_t v);
      return (v == '1) ? v : v + SWAP_W'(1);
   endfunction

endpackage

// File: rtl/compare_sort_ctrl_compare.sv
// The shared 4-bit magnitude comparator; exactly one of the three flags is high.
module compare
   import compare_sort_ctrl_pkg::*;
(
   input  logic [CMP_W-1:0] in1,
   input  logic [CMP_W-1:0] in2,
   output logic             less,
   output logic             equal,
   output logic             bigger
);

   // Pure combinational magnitude decode.
   always_comb begin
      less   = (in1 <  in2);
      equal  = (in1 == in2);
      bigger = (in1 >  in2);
   end

endmodule

// File: rtl/compare_sort_ctrl.sv
// Loads N words, bubble-sorts them in place using one shared comparator
// (one comparison per cycle, fixed (N-1)*(N-1) cycles), then streams them out.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for the first word of a batch, in_ready high
// ST_LOAD  | filling data_q[1..N-1], in_ready high
// ST_SORT  | one compare/swap of data_q[j], data_q[j+1] per cycle
// ST_OUT   | presenting data_q[rd_idx] on out_data until all N are taken
module compare_sort_ctrl
   import compare_sort_ctrl_pkg::*;
#(
   parameter int N = 4,
   parameter int W = CMP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [W-1:0]      in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [SWAP_W-1:0] swaps
);

   localparam int            IW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST   = IW'(N - 1);
   localparam logic [IW-1:0] LAST_J = IW'(N - 2);

   logic [1:0]        state_q, state_d;
   logic [W-1:0]      data_q [N];
   logic [W-1:0]      data_d [N];
   logic [IW-1:0]     wr_idx_q, wr_idx_d;
   logic [IW-1:0]     rd_idx_q, rd_idx_d;
   logic [IW-1:0]     j_q, j_d;
   logic [IW-1:0]     pass_q, pass_d;
   logic [IW-1:0]     j_nxt;
   swap_cnt_t         swaps_q, swaps_d;
   logic              out_valid_q, out_valid_d;
   logic [W-1:0]      out_data_q, out_data_d;
   logic              done_q, done_d;
   logic              cmp_less, cmp_equal, cmp_bigger;

   assign j_nxt = j_q + IW'(1);

   compare u_compare (
      .in1    (data_q[j_q]),
      .in2    (data_q[j_nxt]),
      .less   (cmp_less),
      .equal  (cmp_equal),
      .bigger (cmp_bigger)
   );

   // Only a strictly-greater result swaps; less/equal keep order, which keeps the sort stable.
   logic unused_cmp;
   assign unused_cmp = cmp_less ^ cmp_equal;

   // Next-state logic for the sequencer, buffer and output register.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      j_d         = j_q;
      pass_d      = pass_q;
      swaps_d     = swaps_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d[0] = in_data;
               wr_idx_d  = IW'(1);
               swaps_d   = '0;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               data_d[wr_idx_q] = in_data;
               if (wr_idx_q == LAST) begin
                  state_d = ST_SORT;
                  j_d     = '0;
                  pass_d  = '0;
               end else begin
                  wr_idx_d = wr_idx_q + IW'(1);
               end
            end
         end
         ST_SORT: begin
            if (cmp_bigger) begin
               data_d[j_q]   = data_q[j_nxt];
               data_d[j_nxt] = data_q[j_q];
               swaps_d       = sat_inc(swaps_q);
            end
            if (j_q == LAST_J) begin
               j_d = '0;
               if (pass_q == LAST_J) begin
                  // data_d[0] already reflects a swap made on this same edge.
                  state_d     = ST_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = data_d[0];
                  rd_idx_d    = '0;
               end else begin
                  pass_d = pass_q + IW'(1);
               end
            end else begin
               j_d = j_nxt;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               if (rd_idx_q == LAST) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  rd_idx_d   = rd_idx_q + IW'(1);
                  out_data_d = data_q[rd_idx_q + IW'(1)];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial batch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_q      <= '{default: '0};
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         j_q         <= '0;
         pass_q      <= '0;
         swaps_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         j_q         <= j_d;
         pass_q      <= pass_d;
         swaps_q     <= swaps_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign swaps     = swaps_q;

endmodule
